key_clk_cond: RTL and testbench

//   Front-end conditioning stage feeding the 2-digit hex up/down counter/display block.

---
 rtl/key_clk_cond.sv | 127 ++++++++++++
 tb/tb_key_clk_cond.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_clk_cond.sv
// Key conditioning front end: 2-FF synchronisers, per-key debounce, count-key strobe,
// direction toggle flag and two 50%-duty clock dividers, all on clk100khz.
module key_clk_cond #(
  parameter int DB_TICKS = 2000,
  parameter int DIV_10HZ = 10000,
  parameter int DIV_1HZ  = 100000
) (
  input  logic clk100khz,
  input  logic rst,
  input  logic key_cnt_n,
  input  logic key_dir_n,
  output logic clk10hz,
  output logic clk1hz,
  output logic key_db_n,
  output logic key_pulse,
  output logic flag
);

  localparam int DB_W = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;

  genvar gi;

  // Index 0 is the count key, index 1 the direction key.
  logic [1:0] raw_keys;
  logic [1:0] st_vec;
  logic [1:0] fall_vec;
  logic [1:0] div_vec;

  assign raw_keys = {key_dir_n, key_cnt_n};

  generate
    for (gi = 0; gi < 2; gi++) begin : g_key
      logic            s1_q;
      logic            s2_q;
      logic            st_q;
      logic            st_d;
      logic [DB_W-1:0] dc_q;
      logic [DB_W-1:0] dc_d;

      // Any sample agreeing with the stable level restarts the count.
      always_comb begin
        dc_d = '0;
        st_d = st_q;
        if (s2_q != st_q) begin
          if (dc_q == DB_W'(DB_TICKS - 1)) begin
            st_d = s2_q;
          end else begin
            dc_d = dc_q + DB_W'(1);
          end
        end
      end

      always_ff @(posedge clk100khz or negedge rst) begin
        if (!rst) begin
          s1_q <= 1'b1;
          s2_q <= 1'b1;
          st_q <= 1'b1;
          dc_q <= '0;
        end else begin
          s1_q <= raw_keys[gi];
          s2_q <= s1_q;
          st_q <= st_d;
          dc_q <= dc_d;
        end
      end

      assign st_vec[gi]   = st_q;
      assign fall_vec[gi] = st_q & ~st_d;
    end

    for (gi = 0; gi < 2; gi++) begin : g_div
      localparam int DIV = (gi == 0) ? DIV_10HZ : DIV_1HZ;
      localparam int CW  = $clog2(DIV);

      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;
      logic          out_q;
      logic          out_d;

      // Toggling at the half-period and wrap points gives an exact 50% duty cycle.
      always_comb begin
        cnt_d = (cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + CW'(1);
        out_d = out_q ^ ((cnt_q == CW'(DIV / 2 - 1)) || (cnt_q == CW'(DIV - 1)));
      end

      always_ff @(posedge clk100khz or negedge rst) begin
        if (!rst) begin
          cnt_q <= '0;
          out_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          out_q <= out_d;
        end
      end

      assign div_vec[gi] = out_q;
    end
  endgenerate

  logic key_pulse_q;
  logic key_pulse_d;
  logic flag_q;
  logic flag_d;

  // Only the press (1->0 acceptance) matters; releases are ignored.
  always_comb begin
    key_pulse_d = fall_vec[0];
    flag_d      = flag_q ^ fall_vec[1];
  end

  always_ff @(posedge clk100khz or negedge rst) begin
    if (!rst) begin
      key_pulse_q <= 1'b0;
      flag_q      <= 1'b1;
    end else begin
      key_pulse_q <= key_pulse_d;
      flag_q      <= flag_d;
    end
  end

  assign clk10hz   = div_vec[0];
  assign clk1hz    = div_vec[1];
  assign key_db_n  = st_vec[0];
  assign key_pulse = key_pulse_q;
  assign flag      = flag_q;

endmodule

// File: tb/tb_key_clk_cond.sv
// Bench for key_clk_cond: per-cycle comparison against a sample-history reference model,
// a table of key segments with end-of-segment expectations, and timing/reset corner cases.
module tb_key_clk_cond;

  localparam int DB  = 8;
  localparam int D10 = 10;
  localparam int D1  = 100;

  logic clk100khz = 1'b0;
  logic rst       = 1'b0;
  logic key_cnt_n = 1'b1;
  logic key_dir_n = 1'b1;
  logic clk10hz, clk1hz, key_db_n, key_pulse, flag;

  key_clk_cond #(.DB_TICKS(DB), .DIV_10HZ(D10), .DIV_1HZ(D1)) dut (
    .clk100khz(clk100khz),
    .rst      (rst),
    .key_cnt_n(key_cnt_n),
    .key_dir_n(key_dir_n),
    .clk10hz  (clk10hz),
    .clk1hz   (clk1hz),
    .key_db_n (key_db_n),
    .key_pulse(key_pulse),
    .flag     (flag)
  );

  always #5 clk100khz = ~clk100khz;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 30)
        $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a key is accepted once the synchronised sample has disagreed with
  // the stable level for DB consecutive cycles; dividers follow from the edge count.
  bit m_s1 [2];
  bit m_st [2];
  bit m_h  [2][DB];
  int m_ec;
  bit m_pulse;
  bit m_flag;

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_s1[k] = 1'b1;
      m_st[k] = 1'b1;
      for (int i = 0; i < DB; i++) m_h[k][i] = 1'b1;
    end
    m_ec    = 0;
    m_pulse = 1'b0;
    m_flag  = 1'b1;
  endtask

  task automatic m_step();
    bit raw [2];
    bit fell[2];
    bit acc;
    raw[0] = key_cnt_n;
    raw[1] = key_dir_n;
    for (int k = 0; k < 2; k++) begin
      acc = 1'b1;
      for (int i = 0; i < DB; i++) if (m_h[k][i] == m_st[k]) acc = 1'b0;
      fell[k] = acc && m_st[k];
      if (acc) m_st[k] = ~m_st[k];
      for (int i = DB - 1; i > 0; i--) m_h[k][i] = m_h[k][i-1];
      m_h[k][0] = m_s1[k];
      m_s1[k]   = raw[k];
    end
    m_pulse = fell[0];
    if (fell[1]) m_flag = ~m_flag;
    m_ec++;
  endtask

  function automatic bit div_exp(input int div);
    return ((m_ec / (div / 2)) % 2) == 1;
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk100khz or negedge rst);
      if (!rst) m_reset();
      else m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk100khz);
      if (chk_en) begin
        chk("clk10hz",   clk10hz,   div_exp(D10));
        chk("clk1hz",    clk1hz,    div_exp(D1));
        chk("key_db_n",  key_db_n,  m_st[0]);
        chk("key_pulse", key_pulse, m_pulse);
        chk("flag",      flag,      m_flag);
      end
    end
  end

  typedef struct {
    bit cnt_n;
    bit dir_n;
    int cycles;
    bit exp_db_n;
    bit exp_flag;
    int exp_pulses;
  } seg_t;

  seg_t tbl[15];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int first10, first1, found, np;

    tbl[0]  = '{1, 1, 30, 1, 1, 0};
    tbl[1]  = '{0, 1, 40, 0, 1, 1};
    tbl[2]  = '{1, 1, 30, 1, 1, 0};
    tbl[3]  = '{0, 1,  5, 1, 1, 0};
    tbl[4]  = '{1, 1,  2, 1, 1, 0};
    tbl[5]  = '{0, 1,  5, 1, 1, 0};
    tbl[6]  = '{1, 1, 20, 1, 1, 0};
    tbl[7]  = '{1, 0, 20, 1, 0, 0};
    tbl[8]  = '{1, 1, 20, 1, 0, 0};
    tbl[9]  = '{1, 0, 20, 1, 1, 0};
    tbl[10] = '{1, 1, 20, 1, 1, 0};
    tbl[11] = '{1, 0, 20, 1, 0, 0};
    tbl[12] = '{1, 1, 20, 1, 0, 0};
    tbl[13] = '{0, 0, 20, 0, 1, 1};
    tbl[14] = '{1, 1, 20, 1, 1, 0};

    rst = 1'b0;
    repeat (3) @(negedge clk100khz);
    chk("rst_clk10hz",   clk10hz,   0);
    chk("rst_clk1hz",    clk1hz,    0);
    chk("rst_key_db_n",  key_db_n,  1);
    chk("rst_key_pulse", key_pulse, 0);
    chk("rst_flag",      flag,      1);
    chk_en = 1'b1;
    rst    = 1'b1;

    first10 = 0;
    first1  = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk100khz);
      if (clk10hz === 1'b1 && first10 == 0) first10 = k;
      if (clk1hz === 1'b1 && first1 == 0) first1 = k;
    end
    chk("first_rise_10hz", first10, 5);
    chk("first_rise_1hz",  first1,  50);
    $display("startup: clk10hz first high after edge %0d, clk1hz after edge %0d", first10, first1);

    key_cnt_n = 1'b0;
    found = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk100khz);
      if (found == 0 && key_db_n === 1'b0) begin
        found = k;
        chk("pulse_at_accept", key_pulse, 1);
      end
    end
    chk("cnt_latency", found, 10);
    $display("press: key_db_n fell after edge %0d", found);
    key_cnt_n = 1'b1;
    repeat (30) @(negedge clk100khz);

    for (int r = 0; r < 15; r++) begin
      key_cnt_n = tbl[r].cnt_n;
      key_dir_n = tbl[r].dir_n;
      np = 0;
      for (int c = 0; c < tbl[r].cycles; c++) begin
        @(negedge clk100khz);
        if (key_pulse === 1'b1) np++;
      end
      chk("seg_key_db_n", key_db_n, tbl[r].exp_db_n);
      chk("seg_flag",     flag,     tbl[r].exp_flag);
      chk("seg_pulses",   np,       tbl[r].exp_pulses);
      $display("row %0d: cnt_n=%0b dir_n=%0b cycles=%0d -> key_db_n=%0b flag=%0b pulses=%0d",
               r, tbl[r].cnt_n, tbl[r].dir_n, tbl[r].cycles, key_db_n, flag, np);
    end

    for (int t = 0; t < 150; t++) begin
      key_cnt_n = 1'($urandom_range(0, 1));
      key_dir_n = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 14)) @(negedge clk100khz);
    end
    $display("random: 150 key segments applied");
    key_cnt_n = 1'b1;
    key_dir_n = 1'b1;
    repeat (30) @(negedge clk100khz);

    // Reset lands between edges while the count key is 5 debounce cycles in.
    key_cnt_n = 1'b0;
    repeat (7) @(negedge clk100khz);
    #2 rst = 1'b0;
    #1;
    chk("midrst_clk10hz",   clk10hz,   0);
    chk("midrst_clk1hz",    clk1hz,    0);
    chk("midrst_key_db_n",  key_db_n,  1);
    chk("midrst_key_pulse", key_pulse, 0);
    chk("midrst_flag",      flag,      1);
    @(negedge clk100khz);
    rst = 1'b1;
    first10 = 0;
    first1  = 0;
    found   = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk100khz);
      if (clk10hz === 1'b1 && first10 == 0) first10 = k;
      if (clk1hz === 1'b1 && first1 == 0) first1 = k;
      if (key_db_n === 1'b0 && found == 0) found = k;
    end
    chk("rerst_latency",    found,   10);
    chk("rerst_rise_10hz",  first10, 5);
    chk("rerst_rise_1hz",   first1,  50);
    $display("after reset: accept edge %0d, clk10hz edge %0d, clk1hz edge %0d", found, first10, first1);
    key_cnt_n = 1'b1;
    repeat (20) @(negedge clk100khz);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
